// File: rtl/wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_arbiter: shares the register-file write port between ALU/LSU/MUL/DIV.
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN          = 32,
  parameter int REG_WIDTH     = 5,
  parameter int DIV_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alu_valid,
  input  logic [REG_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  input  logic [REG_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  input  logic                 mul_valid,
  input  logic [REG_WIDTH-1:0] mul_rd,
  input  logic [XLEN-1:0]      mul_data,
  input  logic                 div_valid,
  output logic                 div_ready,
  input  logic [REG_WIDTH-1:0] div_rd,
  input  logic [XLEN-1:0]      div_data,
  output logic                 wb_wr_en,
  output logic [REG_WIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_wr_data,
  output logic                 div_done,
  output logic                 starve_req,
  output logic                 collision_err
);

  localparam int PTR_W = (DIV_BUF_DEPTH > 1) ? $clog2(DIV_BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(DIV_BUF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DIV_BUF_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_V = STV_W'(STARVE_LIMIT);

  logic [REG_WIDTH-1:0] buf_rd   [DIV_BUF_DEPTH];
  logic [XLEN-1:0]      buf_data [DIV_BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic [STV_W-1:0]     starve_cnt;
  logic [STV_W-1:0]     starve_cnt_nxt;

  logic                 fixed_any;
  logic                 multi_valid;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 div_pop;
  logic                 div_push;
  logic                 win_valid;
  logic [REG_WIDTH-1:0] win_rd;
  logic [XLEN-1:0]      win_data;
  logic                 win_write;

  assign fixed_any   = alu_valid | lsu_valid | mul_valid;
  assign multi_valid = (alu_valid & lsu_valid) | (alu_valid & mul_valid) |
                       (lsu_valid & mul_valid);
  assign buf_empty   = (occ == '0);
  assign buf_full    = (occ == DEPTH_V);
  assign div_pop     = !flush && !fixed_any && !buf_empty;
  assign div_ready   = !buf_full || div_pop;
  assign div_push    = div_valid && div_ready && !flush;

  // Fixed pipes cannot stall, so DIV only ever takes otherwise idle slots.
  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (mul_valid) begin
      win_valid = 1'b1;
      win_rd    = mul_rd;
      win_data  = mul_data;
    end else if (lsu_valid) begin
      win_valid = 1'b1;
      win_rd    = lsu_rd;
      win_data  = lsu_data;
    end else if (alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_data;
    end else if (div_pop) begin
      win_valid = 1'b1;
      win_rd    = buf_rd[rd_ptr];
      win_data  = buf_data[rd_ptr];
    end
  end

  assign win_write = win_valid && (win_rd != '0);

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (flush || div_pop || buf_empty) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != LIMIT_V) begin
      starve_cnt_nxt = starve_cnt + STV_W'(1);
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (div_push) begin
      buf_rd[wr_ptr]   <= div_rd;
      buf_data[wr_ptr] <= div_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (div_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (div_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({div_push, div_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wr_en      <= 1'b0;
      wb_rd         <= '0;
      wb_wr_data    <= '0;
      div_done      <= 1'b0;
      starve_req    <= 1'b0;
      collision_err <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      wb_wr_en      <= win_write;
      wb_rd         <= win_write ? win_rd : '0;
      wb_wr_data    <= win_write ? win_data : '0;
      div_done      <= div_pop;
      starve_cnt    <= starve_cnt_nxt;
      starve_req    <= (starve_cnt_nxt == LIMIT_V);
      collision_err <= collision_err | multi_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_arbiter: table vectors, corner sequences and random traffic vs model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alu_valid, lsu_valid, mul_valid, div_valid;
  logic [4:0]  alu_rd, lsu_rd, mul_rd, div_rd;
  logic [31:0] alu_data, lsu_data, mul_data, div_data;
  logic        div_ready, wb_wr_en, div_done, starve_req, collision_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wr_data;

  wb_arbiter #(.XLEN(32), .REG_WIDTH(5), .DIV_BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data),
    .div_valid(div_valid), .div_ready(div_ready), .div_rd(div_rd), .div_data(div_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_wr_data(wb_wr_data),
    .div_done(div_done), .starve_req(starve_req), .collision_err(collision_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        alu_v; logic [4:0] alu_rd; logic [31:0] alu_d;
    logic        lsu_v; logic [4:0] lsu_rd; logic [31:0] lsu_d;
    logic        mul_v; logic [4:0] mul_rd; logic [31:0] mul_d;
    logic        div_v; logic [4:0] div_rd; logic [31:0] div_d;
    logic        flush;
  } in_t;

  typedef struct {
    in_t         in;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        done;
    logic        coll;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state: DIV results in arrival order, waiting age, sticky flag
  ent_t q[$];
  int   scnt;
  bit   m_coll;
  int   nchecks = 0;
  int   nerr    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t x = '0;
    return x;
  endfunction

  // pipe: 1=ALU 2=LSU 3=MUL
  function automatic in_t fix(input int pipe, input logic [4:0] rd, input logic [31:0] d);
    in_t x = '0;
    case (pipe)
      1: begin x.alu_v = 1'b1; x.alu_rd = rd; x.alu_d = d; end
      2: begin x.lsu_v = 1'b1; x.lsu_rd = rd; x.lsu_d = d; end
      default: begin x.mul_v = 1'b1; x.mul_rd = rd; x.mul_d = d; end
    endcase
    return x;
  endfunction

  function automatic in_t add_div(input in_t b, input logic [4:0] rd, input logic [31:0] d);
    in_t x = b;
    x.div_v = 1'b1; x.div_rd = rd; x.div_d = d;
    return x;
  endfunction

  task automatic drive(input in_t v);
    alu_valid = v.alu_v; alu_rd = v.alu_rd; alu_data = v.alu_d;
    lsu_valid = v.lsu_v; lsu_rd = v.lsu_rd; lsu_data = v.lsu_d;
    mul_valid = v.mul_v; mul_rd = v.mul_rd; mul_data = v.mul_d;
    div_valid = v.div_v; div_rd = v.div_rd; div_data = v.div_d;
    flush     = v.flush;
  endtask

  // Drops reset without waiting for a clock edge, then checks outputs at once.
  task automatic do_reset();
    drive(idle());
    rst = 1'b0;
    #1;
    check("rst_wb_wr_en", wb_wr_en, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_wr_data", wb_wr_data, 0);
    check("rst_div_done", div_done, 0);
    check("rst_starve_req", starve_req, 0);
    check("rst_collision_err", collision_err, 0);
    check("rst_div_ready", div_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    scnt   = 0;
    m_coll = 0;
  endtask

  // One clock: apply inputs, predict from model, compare after the edge.
  task automatic cycle(input in_t v);
    logic        fixed, pop, ready, wv, e_en, e_done;
    logic [4:0]  wrd;
    logic [31:0] wd;
    int          nfix;
    drive(v);
    #1;
    fixed = v.alu_v | v.lsu_v | v.mul_v;
    pop   = !v.flush && !fixed && (q.size() > 0);
    ready = (q.size() < DEPTH) || pop;
    check("div_ready", div_ready, ready);
    wv = 1'b0; wrd = '0; wd = '0;
    if (v.mul_v)      begin wv = 1'b1; wrd = v.mul_rd; wd = v.mul_d; end
    else if (v.lsu_v) begin wv = 1'b1; wrd = v.lsu_rd; wd = v.lsu_d; end
    else if (v.alu_v) begin wv = 1'b1; wrd = v.alu_rd; wd = v.alu_d; end
    else if (pop)     begin wv = 1'b1; wrd = q[0].rd;  wd = q[0].data; end
    nfix = int'(v.alu_v) + int'(v.lsu_v) + int'(v.mul_v);
    if (nfix > 1) m_coll = 1;
    e_en   = wv && (wrd != 0);
    e_done = pop;
    if (v.flush) begin
      q.delete();
      scnt = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        scnt = 0;
      end else if (q.size() > 0) begin
        scnt = (scnt < LIMIT) ? scnt + 1 : LIMIT;
      end else begin
        scnt = 0;
      end
      if (v.div_v && ready) q.push_back('{v.div_rd, v.div_d});
    end
    @(posedge clk);
    #1;
    check("wb_wr_en", wb_wr_en, e_en);
    if (e_en) begin
      check("wb_rd", wb_rd, wrd);
      check("wb_wr_data", wb_wr_data, wd);
    end
    check("div_done", div_done, e_done);
    check("starve_req", starve_req, scnt == LIMIT);
    check("collision_err", collision_err, m_coll);
  endtask

  vec_t tbl[10];
  in_t  t;

  initial begin
    tbl[0] = '{fix(1, 5'd5, 32'h1234), 1, 5, 32'h1234, 0, 0};
    tbl[1] = '{idle(),                 0, 0, 0,          0, 0};
    tbl[2] = '{fix(1, 5'd0, 32'h55),   0, 0, 0,          0, 0};
    tbl[3] = '{add_div(idle(), 5'd7, 32'hAA), 0, 0, 0,   0, 0};
    tbl[4] = '{idle(),                 1, 7, 32'hAA,     1, 0};
    tbl[5] = '{add_div(idle(), 5'd0, 32'h1),  0, 0, 0,   0, 0};
    tbl[6] = '{idle(),                 0, 0, 0,          1, 0};
    tbl[7] = '{fix(2, 5'd9, 32'hBEEF), 1, 9, 32'hBEEF,   0, 0};
    t = fix(3, 5'd3, 32'h33);
    t.alu_v = 1'b1; t.alu_rd = 5'd4; t.alu_d = 32'h44;
    tbl[8] = '{t,                      1, 3, 32'h33,     0, 1};
    tbl[9] = '{idle(),                 0, 0, 0,          0, 1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].in);
      check($sformatf("tbl%0d_en", i), wb_wr_en, tbl[i].en);
      if (tbl[i].en) begin
        check($sformatf("tbl%0d_rd", i), wb_rd, tbl[i].rd);
        check($sformatf("tbl%0d_data", i), wb_wr_data, tbl[i].data);
      end
      check($sformatf("tbl%0d_done", i), div_done, tbl[i].done);
      check($sformatf("tbl%0d_coll", i), collision_err, tbl[i].coll);
    end
    for (int i = 0; i < 3; i++) cycle(fix(1, 5'd2, 32'h2));
    check("coll_sticky", collision_err, 1);

    // Back-pressure and starvation: ALU busy every cycle, three DIV results offered
    do_reset();
    cycle(add_div(fix(1, 5'd1, 32'h100), 5'd11, 32'hB1));
    cycle(add_div(fix(1, 5'd1, 32'h101), 5'd12, 32'hB2));
    check("bp_div_ready_full", div_ready, 0);
    for (int i = 2; i < 8; i++) cycle(add_div(fix(1, 5'd1, 32'h100 + i), 5'd13, 32'hB3));
    check("starve_before_limit", starve_req, 0);
    cycle(add_div(fix(1, 5'd1, 32'h108), 5'd13, 32'hB3));
    check("starve_at_limit", starve_req, 1);
    cycle(add_div(idle(), 5'd13, 32'hB3));
    check("drain0_rd", wb_rd, 11);
    check("drain0_done", div_done, 1);
    check("drain_starve_clr", starve_req, 0);
    cycle(idle());
    check("drain1_rd", wb_rd, 12);
    cycle(idle());
    check("drain2_rd", wb_rd, 13);
    check("drain2_data", wb_wr_data, 32'hB3);
    cycle(idle());
    check("drain_empty_done", div_done, 0);

    // Flush with a full buffer
    do_reset();
    cycle(add_div(fix(3, 5'd6, 32'h60), 5'd14, 32'hC1));
    cycle(add_div(fix(3, 5'd6, 32'h61), 5'd15, 32'hC2));
    t = idle(); t.flush = 1'b1;
    cycle(t);
    check("flush_no_done", div_done, 0);
    check("flush_ready", div_ready, 1);
    check("flush_starve", starve_req, 0);
    cycle(idle());
    check("flush_empty_no_done", div_done, 0);

    // Asynchronous reset while busy
    do_reset();
    cycle(add_div(fix(1, 5'd8, 32'h80), 5'd16, 32'hD1));
    cycle(fix(1, 5'd5, 32'h55));
    check("pre_async_wr_en", wb_wr_en, 1);
    #2;
    do_reset();

    // Random traffic; issue honours starve_req by inserting bubbles
    for (int n = 0; n < 3000; n++) begin
      int r;
      t = idle();
      r = $urandom_range(0, 99);
      if (!(scnt == LIMIT) && r < 60) begin
        t = fix($urandom_range(1, 3), 5'($urandom_range(0, 31)), $urandom);
        if ($urandom_range(0, 99) < 4) begin
          t.alu_v = 1'b1; t.alu_rd = 5'($urandom_range(0, 31)); t.alu_d = $urandom;
        end
      end
      if ($urandom_range(0, 99) < 40) t = add_div(t, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 99) < 3) t.flush = 1'b1;
      cycle(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Owns the single register-file write port and shares it between the EXE pipes: ALU, LSU, MUL and DIV.
- ALU, LSU and MUL have fixed latency and cannot be stalled, so they win the port whenever valid.
- DIV has variable latency; its results are buffered and written only on free cycles.
- Raises a starvation request so issue inserts a bubble, and signals DIV completion back to issue.

Parameters:
- XLEN, 32, data width of write-back.
- REG_WIDTH, 5, register index width.
- DIV_BUF_DEPTH, 2, DIV result buffer entries (power of two, >=2).
- STARVE_LIMIT, 8, cycles a DIV result may wait before a bubble is requested (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  branch redirect; drops buffered DIV results
- alu_valid, lsu_valid, mul_valid  in  1 each  result valid from fixed pipe
- alu_rd, lsu_rd, mul_rd  in  REG_WIDTH each  destination register
- alu_data, lsu_data, mul_data  in  XLEN each  result data
- div_valid  in  1  DIV result valid
- div_ready  out  1  DIV buffer can accept this cycle
- div_rd  in  REG_WIDTH  DIV destination
- div_data  in  XLEN  DIV result
- wb_wr_en  out  1  register-file write enable
- wb_rd  out  REG_WIDTH  write index
- wb_wr_data  out  XLEN  write data
- div_done  out  1  pulse: DIV result written back
- starve_req  out  1  issue must not fire an ALU/LSU/MUL op next cycle
- collision_err  out  1  sticky: two fixed pipes valid at once

Behaviour:
- Reset (rst low, async): wb_wr_en=0, wb_rd=0, wb_wr_data=0, div_done=0, starve_req=0, collision_err=0, buffer empty, div_ready=1, starve counter=0.
- All outputs are registered: a winner in cycle N drives wb_* in cycle N+1 (latency 1).

Priority and winner selection (combinational, in cycle N):
- Order is MUL > LSU > ALU > DIV buffer head.
- At most one fixed pipe is expected valid. If two or more are valid, the highest-priority one is written, the others are dropped, and collision_err sets and stays set until reset.
- DIV wins only when no fixed pipe is valid and the buffer is non-empty. The head is then popped and div_done pulses in N+1 together with wb_wr_en.
- DIV results are always written from the buffer, never bypassed. An accepted result is written no earlier than the cycle after acceptance.

Register 0:
- Any winner with rd==0 produces wb_wr_en=0 for that slot, but the winner is still consumed.
- A DIV winner with rd==0 still pops and still pulses div_done.

DIV buffer:
- FIFO, DIV_BUF_DEPTH entries.
- div_ready = !full || pop_this_cycle.
- Push when div_valid && div_ready && !flush.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.

Flush:
- flush=1 clears the buffer synchronously and suppresses that cycle's DIV push and pop; no div_done is produced.
- Fixed-pipe winners are still written during flush. Squashing them is upstream's job.
- Starve counter resets to 0.

Starvation:
- The counter increments each cycle the buffer is non-empty and DIV loses arbitration.
- It clears to 0 on a DIV pop, on flush, or when the buffer is empty, and saturates at STARVE_LIMIT.
- starve_req (registered) = 1 while counter==STARVE_LIMIT.
- Issue honours starve_req, guaranteeing a free slot within 3 cycles (MUL depth). That slot pops DIV and the counter clears.

Test Plan:
- Single ALU op: alu_valid rd=5 data=0x1234 in cycle 0 -> wb_wr_en=1, wb_rd=5, wb_wr_data=0x1234 in cycle 1; idle otherwise.
- Collision: mul_valid rd=3 and alu_valid rd=4 in the same cycle -> only rd=3 written; collision_err=1 and stays 1 until reset.
- DIV on idle port: div_valid rd=7 data=0xAA in cycle 0 with fixed pipes idle -> wb_rd=7, wb_wr_data=0xAA and div_done=1 in cycle 2.
- Back-pressure: fixed pipes valid every cycle, push 3 DIV results -> div_ready=0 after 2 accepted; starve_req=1 after 8 losing cycles; first idle slot drains entries in FIFO order with one div_done per entry.
- Flush: buffer holding 2 DIV results, assert flush -> no div_done, buffer empty, div_ready=1, starve_req=0 next cycle.
- Async reset mid-operation: drop rst while buffer is non-empty and wb_wr_en=1 -> all outputs 0 immediately, with no clock edge required.
